// File: rtl/esp_dma32_read_burst_splitter.sv
// Splits one long DMA read into ESP bursts of at most MAX_BURST beats, buffering returned beats in a credit-protected FIFO.
// Optional macro ESP_DMA32_SPLIT_4KB_EN: additionally keeps every burst inside one 1024-word (4 KB) window.
module esp_dma32_read_burst_splitter #(
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_index,
  input  logic [31:0] req_length,
  input  logic [2:0]  req_size,
  output logic        dma_read_ctrl_valid,
  input  logic        dma_read_ctrl_ready,
  output logic [31:0] dma_read_ctrl_data_index,
  output logic [31:0] dma_read_ctrl_data_length,
  output logic [2:0]  dma_read_ctrl_data_size,
  input  logic        dma_read_chnl_valid,
  output logic        dma_read_chnl_ready,
  input  logic [31:0] dma_read_chnl_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0]   MAX_BURST_W = 32'(MAX_BURST);
  localparam logic [31:0]   DEPTH_W     = 32'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   cur_idx_q, cur_idx_d;
  logic [31:0]   remaining_q, remaining_d;
  logic [31:0]   beats_left_q, beats_left_d;
  logic [2:0]    size_q, size_d;
  logic          done_q, done_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   blen;
  logic          credit_ok, push, pop;

`ifdef ESP_DMA32_SPLIT_4KB_EN
  logic [31:0]   room;
`endif

  always_comb begin
    blen = (remaining_q < MAX_BURST_W) ? remaining_q : MAX_BURST_W;
`ifdef ESP_DMA32_SPLIT_4KB_EN
    room = 32'd1024 - {22'd0, cur_idx_q[9:0]};
    if (room < blen) blen = room;
`endif
  end

  // Credit uses registered occupancy only; no beat of this burst is in flight yet.
  assign credit_ok = (DEPTH_W - 32'(count_q)) >= blen;

  assign req_ready                 = (state_q == S_IDLE);
  assign dma_read_ctrl_valid       = (state_q == S_ISSUE) && credit_ok;
  assign dma_read_ctrl_data_index  = cur_idx_q;
  assign dma_read_ctrl_data_length = blen;
  assign dma_read_ctrl_data_size   = size_q;
  assign dma_read_chnl_ready       = (state_q == S_STREAM) && (count_q != DEPTH_C);
  assign out_valid                 = (count_q != '0);
  assign out_data                  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy                      = (state_q != S_IDLE);
  assign done                      = done_q;
  assign push                      = dma_read_chnl_valid && dma_read_chnl_ready;
  assign pop                       = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    cur_idx_d    = cur_idx_q;
    remaining_d  = remaining_q;
    beats_left_d = beats_left_q;
    size_d       = size_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cur_idx_d   = req_index;
          remaining_d = req_length;
          size_d      = req_size;
          if (req_length == '0) done_d = 1'b1;
          else                  state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
          cur_idx_d    = cur_idx_q + blen;
          remaining_d  = remaining_q - blen;
          beats_left_d = blen;
          state_d      = S_STREAM;
        end
      end
      S_STREAM: begin
        if (push) begin
          beats_left_d = beats_left_q - 32'd1;
          if (beats_left_q == 32'd1) state_d = (remaining_q != '0) ? S_ISSUE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && (count_q == CW'(1))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_idx_q    <= '0;
      remaining_q  <= '0;
      beats_left_q <= '0;
      size_q       <= '0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_idx_q    <= cur_idx_d;
      remaining_q  <= remaining_d;
      beats_left_q <= beats_left_d;
      size_q       <= size_d;
      done_q       <= done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dma_read_chnl_data;
  end

endmodule

// File: tb/tb_esp_dma32_read_burst_splitter.sv
// Self-checking bench for esp_dma32_read_burst_splitter: table-driven requests, hand sequences and randomized traffic.
// Expected bursts honour ESP_DMA32_SPLIT_4KB_EN when the bench is built with it.
module tb_esp_dma32_read_burst_splitter;

  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_index, req_length;
  logic [2:0]  req_size;
  logic        ctrl_valid, ctrl_ready;
  logic [31:0] ctrl_index, ctrl_length;
  logic [2:0]  ctrl_size;
  logic        chnl_valid, chnl_ready;
  logic [31:0] chnl_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        busy, done;

  esp_dma32_read_burst_splitter #(.MAX_BURST(16), .FIFO_DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_length(req_length), .req_size(req_size),
    .dma_read_ctrl_valid(ctrl_valid), .dma_read_ctrl_ready(ctrl_ready),
    .dma_read_ctrl_data_index(ctrl_index), .dma_read_ctrl_data_length(ctrl_length),
    .dma_read_ctrl_data_size(ctrl_size),
    .dma_read_chnl_valid(chnl_valid), .dma_read_chnl_ready(chnl_ready),
    .dma_read_chnl_data(chnl_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] idx; logic [31:0] len; } burst_t;
  typedef struct {
    logic [31:0] idx; logic [31:0] len; int mode;
    int nb; logic [31:0] lidx; logic [31:0] llen;
  } vec_t;

  burst_t      exp_bursts[$];
  logic [31:0] exp_data[$];
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, acc_cyc = 0, cur_mode = 0, model_nb = 0;
  int          done_cnt, done_cyc, first_ctrl_cyc, last_beat_cyc;
  int          esp_left = 0, esp_accepted, occ = 0, max_occ, obs_n;
  logic [31:0] esp_idx = '0, obs_lidx, obs_llen, next_idx, next_len;
  logic [2:0]  cur_size;
  bit          ready_dropped;

  function automatic logic [31:0] hashWord(input logic [31:0] w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: split the request arithmetically and list every word it must deliver.
  task automatic buildModel(input logic [31:0] idx, input logic [31:0] len);
    logic [31:0] cur, rem, b;
    exp_bursts.delete();
    exp_data.delete();
    cur = idx;
    rem = len;
    while (rem != 0) begin
      b = (rem < MAXB) ? rem : MAXB;
`ifdef ESP_DMA32_SPLIT_4KB_EN
      if (1024 - (cur % 1024) < b) b = 1024 - (cur % 1024);
`endif
      exp_bursts.push_back('{cur, b});
      cur += b;
      rem -= b;
    end
    model_nb = exp_bursts.size();
    for (int k = 0; k < int'(len); k++) exp_data.push_back(hashWord(idx + k));
  endtask

  // One clock: drive at negedge, then observe handshakes that complete at the next posedge.
  task automatic applyStimulus(input bit do_req);
    burst_t b;
    @(negedge clk);
    cyc++;
    req_valid = do_req;
    if (do_req) begin
      req_index = next_idx;
      req_length = next_len;
      req_size = cur_size;
    end
    case (cur_mode)
      1:       begin ctrl_ready = 1'($urandom_range(0, 1)); out_ready = ($urandom_range(0, 9) < 7); end
      2:       begin ctrl_ready = 1'b1; out_ready = ((cyc - acc_cyc) >= 100); end
      3:       begin ctrl_ready = 1'b1; out_ready = 1'b0; end
      default: begin ctrl_ready = 1'b1; out_ready = 1'b1; end
    endcase
    chnl_valid = (esp_left != 0) && (cur_mode != 1 || $urandom_range(0, 3) != 0);
    chnl_data = hashWord(esp_idx);
    #1;
    if (do_req) checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    if (!req_ready) ready_dropped = 1'b1;
    if (ctrl_valid) begin
      if (first_ctrl_cyc < 0) first_ctrl_cyc = cyc;
      if (cur_mode == 0 && last_beat_cyc >= 0) begin
        checkOutput("reissue_gap", 32'(cyc - last_beat_cyc), 32'd1);
        last_beat_cyc = -1;
      end
    end
    if (ctrl_valid && ctrl_ready) begin
      if (exp_bursts.size() == 0) checkOutput("burst_extra", 32'd1, 32'd0);
      else begin
        b = exp_bursts.pop_front();
        checkOutput("burst_idx", ctrl_index, b.idx);
        checkOutput("burst_len", ctrl_length, b.len);
        checkOutput("burst_size", 32'(ctrl_size), 32'(cur_size));
      end
      obs_n++;
      obs_lidx = ctrl_index;
      obs_llen = ctrl_length;
      esp_idx = ctrl_index;
      esp_left = int'(ctrl_length);
    end
    if (chnl_valid && chnl_ready) begin
      esp_idx++;
      esp_left--;
      esp_accepted++;
      occ++;
      if (esp_left == 0) last_beat_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (exp_data.size() == 0) checkOutput("beat_extra", 32'd1, 32'd0);
      else checkOutput("beat_data", out_data, exp_data.pop_front());
      occ--;
    end
    if (occ > max_occ) max_occ = occ;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      checkOutput("ready_with_done", 32'(req_ready), 32'd1);
    end
    if (cur_mode == 2 && (cyc - acc_cyc) == 99) begin
      checkOutput("bp_beats_buffered", 32'(esp_accepted), 32'd32);
      checkOutput("bp_ctrl_held_low", 32'(ctrl_valid), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    end
  endtask

  task automatic startRequest(input logic [31:0] idx, input logic [31:0] len, input int mode);
    buildModel(idx, len);
    cur_mode = mode;
    cur_size = 3'($urandom_range(0, 7));
    next_idx = idx;
    next_len = len;
    done_cnt = 0; done_cyc = -1; first_ctrl_cyc = -1; last_beat_cyc = -1;
    esp_accepted = 0; max_occ = 0; obs_n = 0; obs_lidx = '0; obs_llen = '0;
    ready_dropped = 1'b0;
    acc_cyc = cyc + 1;
    applyStimulus(1'b1);
  endtask

  task automatic runRequest(input logic [31:0] idx, input logic [31:0] len, input int mode);
    startRequest(idx, len, mode);
    while (done_cnt == 0 && (cyc - acc_cyc) < 3000) applyStimulus(1'b0);
    if (done_cnt == 0) checkOutput("done_timeout", 32'd0, 32'd1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("done_once", 32'(done_cnt), 32'd1);
    checkOutput("bursts_left", 32'(exp_bursts.size()), 32'd0);
    checkOutput("beats_left", 32'(exp_data.size()), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("max_buffered_ok", 32'(max_occ <= 32), 32'd1);
    if (len == 0) begin
      checkOutput("len0_done_latency", 32'(done_cyc - acc_cyc), 32'd1);
      checkOutput("len0_no_ctrl", 32'(first_ctrl_cyc < 0), 32'd1);
      checkOutput("len0_req_ready", 32'(ready_dropped), 32'd0);
    end else if (mode == 0) begin
      checkOutput("ctrl_latency", 32'(first_ctrl_cyc - acc_cyc), 32'd1);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_ctrl_valid"}, 32'(ctrl_valid), 32'd0);
    checkOutput({tag, "_ctrl_index"}, ctrl_index, 32'd0);
    checkOutput({tag, "_ctrl_length"}, ctrl_length, 32'd0);
    checkOutput({tag, "_ctrl_size"}, 32'(ctrl_size), 32'd0);
    checkOutput({tag, "_chnl_ready"}, 32'(chnl_ready), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_data"}, out_data, 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h00000100, 32'd40, 0, 3, 32'h00000120, 32'd8};
    vecs[1] = '{32'h00000000, 32'd0,  0, 0, 32'h00000000, 32'd0};
`ifdef ESP_DMA32_SPLIT_4KB_EN
    vecs[2] = '{32'h000003FA, 32'd12, 0, 2, 32'h00000400, 32'd6};
    vecs[3] = '{32'hFFFFFFF8, 32'd16, 0, 2, 32'h00000000, 32'd8};
    vecs[4] = '{32'hFFFFFFF8, 32'd24, 0, 2, 32'h00000000, 32'd16};
`else
    vecs[2] = '{32'h000003FA, 32'd12, 0, 1, 32'h000003FA, 32'd12};
    vecs[3] = '{32'hFFFFFFF8, 32'd16, 0, 1, 32'hFFFFFFF8, 32'd16};
    vecs[4] = '{32'hFFFFFFF8, 32'd24, 0, 2, 32'h00000008, 32'd8};
`endif
    vecs[5] = '{32'h00000007, 32'd33, 1, 3, 32'h00000027, 32'd1};

    rst = 1'b1;
    req_valid = 1'b0; req_index = '0; req_length = '0; req_size = '0;
    ctrl_ready = 1'b0; chnl_valid = 1'b0; chnl_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      runRequest(vecs[i].idx, vecs[i].len, vecs[i].mode);
      checkOutput("vec_nbursts", 32'(obs_n), 32'(vecs[i].nb));
      if (vecs[i].nb > 0) begin
        checkOutput("vec_last_idx", obs_lidx, vecs[i].lidx);
        checkOutput("vec_last_len", obs_llen, vecs[i].llen);
      end
    end

    // Upstream stalled for 100 cycles: buffering must stop at FIFO capacity without losing data.
    runRequest(32'h00002000, 32'd64, 2);
    checkOutput("bp_nbursts", 32'(obs_n), 32'd4);

    // Reset while streaming with five beats buffered, then a clean request.
    startRequest(32'h00000500, 32'd20, 3);
    while (esp_accepted < 5 && (cyc - acc_cyc) < 200) applyStimulus(1'b0);
    checkOutput("pre_reset_beats", 32'(esp_accepted), 32'd5);
    @(negedge clk);
    cyc++;
    rst = 1'b1; req_valid = 1'b0; chnl_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    cyc++;
    #1;
    checkResetValues("midrst");
    rst = 1'b0;
    esp_left = 0;
    occ = 0;
    runRequest(32'h00000600, 32'd24, 1);

    for (int i = 0; i < 8; i++) begin
      runRequest($urandom, 32'($urandom_range(0, 80)), 1);
      checkOutput("rand_nbursts", 32'(obs_n), 32'(model_nb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/esp_dma32_read_burst_splitter.md
# esp_dma32_read_burst_splitter

Sits between the X-HEEP wrapper's DMA read request path and the ESP `dma_read_ctrl`/`dma_read_chnl` ports. It splits one long read request into bursts of at most `MAX_BURST` beats, with at most one burst outstanding at a time. Returning beats are buffered in a credit-protected FIFO and streamed upstream with valid/ready. The ESP read channel therefore never back-pressures mid-burst, even when the upstream consumer (boot loader or OBI bridge) stalls.

## Interface
- `MAX_BURST`, 16, maximum beats per issued ESP burst; range 1..FIFO_DEPTH.
- `FIFO_DEPTH`, 32, data FIFO entries; power of two, ≥ MAX_BURST.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  upstream request valid.
- `req_ready`  out  1  request accepted when high with req_valid.
- `req_index`  in  32  start word index.
- `req_length`  in  32  total beats (32-bit words).
- `req_size`  in  3  beat size code, forwarded unchanged.
- `dma_read_ctrl_valid`  out  1  ESP burst request valid.
- `dma_read_ctrl_ready`  in  1  ESP accepts burst.
- `dma_read_ctrl_data_index`  out  32  burst start word index.
- `dma_read_ctrl_data_length`  out  32  burst beats.
- `dma_read_ctrl_data_size`  out  3  latched req_size.
- `dma_read_chnl_valid`  in  1  ESP beat valid.
- `dma_read_chnl_ready`  out  1  FIFO can accept beat.
- `dma_read_chnl_data`  in  32  ESP beat data.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  upstream pops beat.
- `out_data`  out  32  FIFO head.
- `busy`  out  1  request in progress (not IDLE).
- `done`  out  1  one-cycle pulse: last beat of the request popped.

## Operation
- FSM: IDLE, ISSUE, STREAM, DRAIN.
- IDLE: req_ready=1. On req_valid, latch index into cur_idx, length into remaining and size.
  - Length 0 → stay IDLE, pulse `done` next cycle, no ESP traffic.
  - Otherwise → ISSUE.
- ISSUE: blen = min(remaining, MAX_BURST); with macro, further clipped (see Configuration).
  - Assert ctrl_valid only when FIFO free entries ≥ blen (credit check). Free entries include the effect of a pop in the same cycle on the next evaluation only.
  - index/length/size are registered and held stable while valid && !ready.
  - On ready: cur_idx += blen (mod 2^32), remaining −= blen, beats_left = blen → STREAM.
- STREAM: dma_read_chnl_ready = FIFO not full, which is always true by credit. Each accepted beat is pushed and decrements beats_left.
  - When beats_left reaches 0: remaining ≠ 0 → ISSUE; else → DRAIN.
- DRAIN: wait until FIFO empty with the final pop. `done` pulses in the cycle after that last pop; → IDLE.
- The FIFO supports simultaneous push and pop, including full and empty; occupancy is unchanged.
- Beats arriving in IDLE or ISSUE are not accepted: chnl_ready=0 there.
- Reset mid-operation: FSM → IDLE, FIFO flushed, counters cleared. Any in-flight ESP burst is abandoned and recovery is the ESP side's responsibility.

## Timing
- Reset values: req_ready=1, dma_read_ctrl_valid=0, ctrl index/length/size=0, dma_read_chnl_ready=0, out_valid=0, out_data=0, busy=0, done=0.
- Request accept → ctrl_valid: 1 cycle, assuming credit is available.
- Beat accepted on ESP → out_valid: 1 cycle (registered FIFO write, head visible next cycle).
- Last burst beat accepted → next ctrl_valid: 1 cycle minimum.
- Sustained throughput: 1 beat/cycle within a burst; 2-cycle gap between bursts (STREAM→ISSUE→handshake).
- `done` is high exactly one cycle; req_ready returns high in that same cycle.

## Configuration
- `ESP_DMA32_SPLIT_4KB_EN` defined: blen additionally clipped to 1024 − cur_idx[9:0]. No burst crosses a 4 KB byte boundary (1024-word).
- Undefined: bursts split on length only; boundary crossing is allowed.

## Test plan
- index=0x100, length=40, MAX_BURST=16, always ready → bursts (0x100,16), (0x110,16), (0x120,8). 40 beats out in order, one `done`.
- Length 0 → req_ready=1 throughout, no ctrl_valid, `done` 1 cycle after accept.
- out_ready=0 for 100 cycles, length=64, FIFO_DEPTH=32 → at most 32 beats buffered and ctrl_valid held low once credit is exhausted. No beat lost; resumes when popped.
- Macro on, index=0x3FA, length=12 → bursts (0x3FA,6), (0x400,6). Macro off → single (0x3FA,12).
- Index 0xFFFFFFF8, length=16 → bursts (0xFFFFFFF8,16) issued, and internal cur_idx wraps to 0x00000008 without error.
- rst asserted mid-STREAM with 5 beats buffered → next cycle all outputs at reset values, FIFO empty. A new request then completes normally.
